// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory access controller.
// Holds the EX result, runs one req/ack memory transaction at a time, stalls upstream
// while a transaction is outstanding, and produces the MEM/WB register and forwarding values.
module mem_access_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_wb_ctrl,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_error,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_value,
    output logic              wb_valid,
    output logic [1:0]        wb_ctrl,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_rd
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_error_q, bus_error_d;

    // EX/MEM register
    logic              em_valid_q;
    logic              em_read_q;
    logic              em_write_q;
    logic [1:0]        em_wb_ctrl_q;
    logic [DATA_W-1:0] em_alu_q;
    logic [DATA_W-1:0] em_sdata_q;
    logic [REG_W-1:0]  em_rd_q;

    // MEM/WB register
    logic              wb_valid_q, wb_valid_d;
    logic [1:0]        wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0] wb_read_data_q, wb_read_data_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;

    logic em_is_mem;
    logic em_is_load;
    logic em_aligned;
    logic em_hold;
    logic em_consume;

    // A write wins when both M bits are set, so only read-without-write is a load.
    assign em_is_mem  = em_valid_q & (em_read_q | em_write_q);
    assign em_is_load = em_read_q & ~em_write_q;
    assign em_aligned = (em_alu_q[1:0] == 2'b00);

    // Next state, MEM/WB contents and EX/MEM hold/consume decisions
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_error_d    = 1'b0;
        em_hold        = 1'b0;
        em_consume     = 1'b0;
        wb_valid_d     = 1'b0;
        wb_ctrl_d      = '0;
        wb_read_data_d = '0;
        wb_alu_d       = '0;
        wb_rd_d        = '0;
        unique case (state_q)
            StIdle: begin
                if (em_is_mem) begin
                    if (em_aligned) begin
                        // Keep the entry in EX/MEM: it drives the memory port during BUSY.
                        state_d = StBusy;
                        cnt_d   = '0;
                        em_hold = 1'b1;
                    end else begin
                        bus_error_d = 1'b1;
                    end
                end else if (em_valid_q) begin
                    wb_valid_d = 1'b1;
                    wb_ctrl_d  = em_wb_ctrl_q;
                    wb_alu_d   = em_alu_q;
                    wb_rd_d    = em_rd_q;
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_d        = StIdle;
                    em_consume     = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_ctrl_d      = em_wb_ctrl_q;
                    wb_alu_d       = em_alu_q;
                    wb_rd_d        = em_rd_q;
                    wb_read_data_d = em_is_load ? mem_rdata : '0;
                end else if (cnt_q == LastWait) begin
                    state_d     = StIdle;
                    em_consume  = 1'b1;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state, wait counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // EX/MEM register: capture when not stalled, drop the entry when BUSY ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_valid_q   <= 1'b0;
            em_read_q    <= 1'b0;
            em_write_q   <= 1'b0;
            em_wb_ctrl_q <= '0;
            em_alu_q     <= '0;
            em_sdata_q   <= '0;
            em_rd_q      <= '0;
        end else if (state_q == StIdle && !em_hold) begin
            em_valid_q   <= ex_valid & ~flush;
            em_read_q    <= ex_mem_read;
            em_write_q   <= ex_mem_write;
            em_wb_ctrl_q <= ex_wb_ctrl;
            em_alu_q     <= ex_alu_result;
            em_sdata_q   <= ex_store_data;
            em_rd_q      <= ex_rd;
        end else if (em_consume) begin
            em_valid_q   <= 1'b0;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_ctrl_q      <= '0;
            wb_read_data_q <= '0;
            wb_alu_q       <= '0;
            wb_rd_q        <= '0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_ctrl_q      <= wb_ctrl_d;
            wb_read_data_q <= wb_read_data_d;
            wb_alu_q       <= wb_alu_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    // Outputs: all from registers, no combinational path from mem_ack
    always_comb begin
        stall         = (state_q == StBusy);
        mem_req       = (state_q == StBusy);
        mem_we        = (state_q == StBusy) & em_write_q;
        mem_addr      = em_alu_q;
        mem_wdata     = em_sdata_q;
        bus_error     = bus_error_q;
        // A load's result does not exist yet, so it never forwards from EX/MEM.
        fwd_valid     = em_valid_q & em_wb_ctrl_q[1] & ~(em_read_q & ~em_write_q);
        fwd_rd        = em_rd_q;
        fwd_value     = em_alu_q;
        wb_valid      = wb_valid_q;
        wb_ctrl       = wb_ctrl_q;
        wb_read_data  = wb_read_data_q;
        wb_alu_result = wb_alu_q;
        wb_rd         = wb_rd_q;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (MAX_WAIT = 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, flush;
    logic [1:0]  ex_wb_ctrl;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, mem_req, mem_we, mem_ack, bus_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        fwd_valid, wb_valid;
    logic [4:0]  fwd_rd, wb_rd;
    logic [31:0] fwd_value, wb_read_data, wb_alu_result;
    logic [1:0]  wb_ctrl;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_ctrl(ex_wb_ctrl), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .flush(flush),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_error(bus_error), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_value(fwd_value), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic [1:0] wbc,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r);
        ex_valid      = v;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_wb_ctrl    = wbc;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = r;
    endtask

    task automatic bubble();
        set_ex(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    endtask

    // One active edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        rst = 1'b0;

        // Non-memory op
        set_ex(1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 5'd5);
        tick();
        bubble();
        chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("alu_fwd_value", fwd_value, 32'h10);
        chk("alu_fwd_rd", 32'(fwd_rd), 32'd5);
        chk("alu_stall1", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_alu", wb_alu_result, 32'h10);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_rdata", wb_read_data, 32'h0);
        chk("alu_stall2", 32'(stall), 32'd0);
        mem_ack = 1'b1;  // ack while idle must be ignored
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_ack_stall", 32'(stall), 32'd0);

        // Load acked on its third BUSY cycle; next instruction held upstream
        set_ex(1'b1, 1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd7);
        tick();
        chk("ld_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("ld_req_pre", 32'(mem_req), 32'd0);
        set_ex(1'b1, 1'b0, 1'b0, 2'b10, 32'h55, 32'h0, 5'd9);
        tick();
        chk("ld_req_c1", 32'(mem_req), 32'd1);
        chk("ld_stall_c1", 32'(stall), 32'd1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_wb_bubble", 32'(wb_valid), 32'd0);
        tick();
        chk("ld_req_c2", 32'(mem_req), 32'd1);
        tick();
        chk("ld_req_c3", 32'(mem_req), 32'd1);
        chk("ld_stall_c3", 32'(stall), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        chk("ld_req_done", 32'(mem_req), 32'd0);
        chk("ld_stall_done", 32'(stall), 32'd0);
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_rdata", wb_read_data, 32'hDEADBEEF);
        chk("ld_wb_rd", 32'(wb_rd), 32'd7);
        chk("ld_wb_ctrl", 32'(wb_ctrl), 32'd3);
        chk("ld_consumed", 32'(fwd_valid), 32'd0);
        tick();
        bubble();
        chk("ld_wb_one_cycle", 32'(wb_valid), 32'd0);
        chk("next_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("next_fwd_value", fwd_value, 32'h55);
        chk("next_fwd_rd", 32'(fwd_rd), 32'd9);
        tick();
        chk("next_wb_valid", 32'(wb_valid), 32'd1);
        chk("next_wb_alu", wb_alu_result, 32'h55);

        // Store with both M bits set
        set_ex(1'b1, 1'b1, 1'b1, 2'b00, 32'h200, 32'h1234, 5'd3);
        tick();
        bubble();
        chk("st_req_pre", 32'(mem_req), 32'd0);
        tick();
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_wdata", mem_wdata, 32'h1234);
        tick();
        chk("st_we_hold", 32'(mem_we), 32'd1);
        chk("st_addr_hold", mem_addr, 32'h200);
        chk("st_wdata_hold", mem_wdata, 32'h1234);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_rdata", wb_read_data, 32'h0);
        chk("st_wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("st_req_done", 32'(mem_req), 32'd0);
        tick();

        // Timeout: four BUSY cycles, then abort
        set_ex(1'b1, 1'b1, 1'b0, 2'b11, 32'h300, 32'h0, 5'd4);
        tick();
        bubble();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_stall_c%0d", i + 1), 32'(stall), 32'd1);
            chk($sformatf("to_wb_c%0d", i + 1), 32'(wb_valid), 32'd0);
            chk($sformatf("to_berr_c%0d", i + 1), 32'(bus_error), 32'd0);
        end
        tick();
        chk("to_stall_end", 32'(stall), 32'd0);
        chk("to_req_end", 32'(mem_req), 32'd0);
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        chk("to_bus_error_pulse", 32'(bus_error), 32'd0);
        chk("to_wb_after", 32'(wb_valid), 32'd0);
        chk("to_dropped", 32'(mem_req), 32'd0);

        // Misaligned load
        set_ex(1'b1, 1'b1, 1'b0, 2'b11, 32'h102, 32'h0, 5'd6);
        tick();
        bubble();
        chk("mis_berr_pre", 32'(bus_error), 32'd0);
        tick();
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_bus_error", 32'(bus_error), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        chk("mis_berr_pulse", 32'(bus_error), 32'd0);
        chk("mis_wb_after", 32'(wb_valid), 32'd0);

        // Flush squashes the incoming instruction
        flush = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 2'b11, 32'h400, 32'h0, 5'd8);
        tick();
        set_ex(1'b1, 1'b0, 1'b0, 2'b10, 32'h77, 32'h0, 5'd2);
        chk("fl_ld_fwd", 32'(fwd_valid), 32'd0);
        tick();
        flush = 1'b0;
        bubble();
        chk("fl_ld_req", 32'(mem_req), 32'd0);
        chk("fl_ld_stall", 32'(stall), 32'd0);
        chk("fl_alu_fwd", 32'(fwd_valid), 32'd0);
        tick();
        chk("fl_alu_wb", 32'(wb_valid), 32'd0);

        // Asynchronous reset during BUSY
        set_ex(1'b1, 1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 5'd1);
        tick();
        bubble();
        tick();
        chk("rb_req_busy", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rb_req_async", 32'(mem_req), 32'd0);
        chk("rb_stall_async", 32'(stall), 32'd0);
        chk("rb_wb_async", 32'(wb_valid), 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("rb_req_after", 32'(mem_req), 32'd0);
        chk("rb_wb_after", 32'(wb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
